// File: rtl/common_pkg.sv
// Shared constants and types for the Wishbone-to-async-SRAM responder.
// Supplies bus widths, default SRAM geometry/timing and the FSM state type.
package common_pkg;

    localparam int WB_ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH          = 8;
    localparam int RAM_ADDR_WIDTH      = 17;
    localparam int DEFAULT_WAIT_STATES = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } ram_state_e;

endpackage

// File: rtl/wb_ram_responder.sv
// Wishbone B4 pipelined slave driving an asynchronous SRAM, one transfer
// outstanding, WAIT_STATES extra access cycles per transfer.
//
// Ports:
//   wb_clock_i, reset_i      clock, async active-high reset
//   wb_addr_i/data_i/we_i    request address, write data, direction
//   wb_cycle_i/strobe_i      bus cycle and strobe
//   wb_data_o/ack_o/stall_o  read data, acknowledge, stall
//   ram_addr_o               SRAM address (registered)
//   ram_data_i/ram_data_o    SRAM data in / registered write data out
//   ram_data_oe              block drives the SRAM data lines
//   ram_oe_n_o/ram_we_n_o    active-low SRAM output/write enables
//   ram_wp_i                 write-protect input (WB_RAM_WRITE_PROTECT_EN only)
//
// Build option WB_RAM_WRITE_PROTECT_EN adds ram_wp_i and parameter WP_BASE:
// protected writes at or above WP_BASE run with normal timing and are acked,
// but never assert the SRAM write enable or drive the data lines.
module wb_ram_responder #(
    parameter int WAIT_STATES    = common_pkg::DEFAULT_WAIT_STATES,
    parameter int RAM_ADDR_WIDTH = common_pkg::RAM_ADDR_WIDTH
`ifdef WB_RAM_WRITE_PROTECT_EN
    ,
    parameter logic [RAM_ADDR_WIDTH-1:0] WP_BASE = '1
`endif
) (
    input  logic                                wb_clock_i,
    input  logic                                reset_i,
    input  logic [common_pkg::WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [common_pkg::DATA_WIDTH-1:0]    wb_data_i,
    output logic [common_pkg::DATA_WIDTH-1:0]    wb_data_o,
    input  logic                                wb_we_i,
    input  logic                                wb_cycle_i,
    input  logic                                wb_strobe_i,
    output logic                                wb_stall_o,
    output logic                                wb_ack_o,
    output logic [RAM_ADDR_WIDTH-1:0]           ram_addr_o,
    input  logic [common_pkg::DATA_WIDTH-1:0]    ram_data_i,
    output logic [common_pkg::DATA_WIDTH-1:0]    ram_data_o,
    output logic                                ram_data_oe,
`ifdef WB_RAM_WRITE_PROTECT_EN
    input  logic                                ram_wp_i,
`endif
    output logic                                ram_oe_n_o,
    output logic                                ram_we_n_o
);

    import common_pkg::*;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    ram_state_e                state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic                      wr_q, wr_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic                      doe_q, doe_d;
    logic                      wr_block;
    logic                      unused_addr;

    assign unused_addr = ^wb_addr_i[WB_ADDR_WIDTH-1:RAM_ADDR_WIDTH];

`ifdef WB_RAM_WRITE_PROTECT_EN
    assign wr_block = ram_wp_i
                   && (wb_addr_i[RAM_ADDR_WIDTH-1:0] >= WP_BASE);
`else
    assign wr_block = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        doe_d   = doe_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wb_cycle_i && wb_strobe_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = WS;
                    wr_d    = wb_we_i;
                    addr_d  = wb_addr_i[RAM_ADDR_WIDTH-1:0];
                    wdata_d = wb_data_i;
                    if (wb_we_i) begin
                        oe_n_d = 1'b1;
                        we_n_d = wr_block;
                        doe_d  = !wr_block;
                    end else begin
                        oe_n_d = 1'b0;
                        we_n_d = 1'b1;
                        doe_d  = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    // Release strobes; data lines stay driven through ACK
                    // so the SRAM sees hold time after we_n rises.
                    if (!wr_q) begin
                        rdata_d = ram_data_i;
                    end
                    oe_n_d  = 1'b1;
                    we_n_d  = 1'b1;
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                doe_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            doe_q   <= doe_d;
        end
    end

    // A master that drops its cycle mid-transfer gets no ack.
    assign wb_stall_o  = (state_q != ST_IDLE);
    assign wb_ack_o    = (state_q == ST_ACK) && wb_cycle_i;
    assign wb_data_o   = rdata_q;
    assign ram_addr_o  = addr_q;
    assign ram_data_o  = wdata_q;
    assign ram_data_oe = doe_q;
    assign ram_oe_n_o  = oe_n_q;
    assign ram_we_n_o  = we_n_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
// Randomized self-checking bench for wb_ram_responder with an SRAM model
// and a reference memory image; WB_RAM_WRITE_PROTECT_EN enables the wp test.
module tb_wb_ram_responder;

    localparam int WS = 2;
    localparam int AW = 17;

    logic        clk;
    logic        rst;
    logic [31:0] wb_addr;
    logic [7:0]  wb_wdata;
    logic [7:0]  wb_rdata;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_stall;
    logic        wb_ack;
    logic [AW-1:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        ram_doe;
    logic        ram_oe_n;
    logic        ram_we_n;
`ifdef WB_RAM_WRITE_PROTECT_EN
    logic        ram_wp;
`endif

    int vec;
    int err;

    logic [7:0] sram    [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    logic [7:0] last_rd;
    logic       sram_init;

    wb_ram_responder #(
        .WAIT_STATES    (WS),
        .RAM_ADDR_WIDTH (AW)
`ifdef WB_RAM_WRITE_PROTECT_EN
        ,
        .WP_BASE        (17'h1C000)
`endif
    ) dut (
        .wb_clock_i  (clk),
        .reset_i     (rst),
        .wb_addr_i   (wb_addr),
        .wb_data_i   (wb_wdata),
        .wb_data_o   (wb_rdata),
        .wb_we_i     (wb_we),
        .wb_cycle_i  (wb_cyc),
        .wb_strobe_i (wb_stb),
        .wb_stall_o  (wb_stall),
        .wb_ack_o    (wb_ack),
        .ram_addr_o  (ram_addr),
        .ram_data_i  (ram_din),
        .ram_data_o  (ram_dout),
        .ram_data_oe (ram_doe),
`ifdef WB_RAM_WRITE_PROTECT_EN
        .ram_wp_i    (ram_wp),
`endif
        .ram_oe_n_o  (ram_oe_n),
        .ram_we_n_o  (ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        logic [16:0] a;
        a = 17'(i);
        if (a == 17'h08000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // Asynchronous SRAM: reads while oe_n low, writes on clock edges
    // while we_n low and the data bus is driven.
    assign ram_din = !ram_oe_n ? sram[ram_addr] : 8'hEE;

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] <= init_val(i);
            sram_init <= 1'b1;
        end else if (!ram_we_n && ram_doe) begin
            sram[ram_addr] <= ram_dout;
        end
    end

    // Caller is at a negedge; k counts samples after the accept edge.
    task automatic xfer(
        input  logic        w,
        input  logic [16:0] a,
        input  logic [7:0]  d,
        input  bit          drop,
        output int          stall_n,
        output int          oe_n_cnt,
        output int          we_n_cnt,
        output int          doe_n,
        output int          ack_k,
        output int          ack_n,
        output logic [7:0]  rd,
        output bit          addr_ok,
        output bit          wd_ok
    );
        stall_n  = 0;
        oe_n_cnt = 0;
        we_n_cnt = 0;
        doe_n    = 0;
        ack_k    = -1;
        ack_n    = 0;
        rd       = 8'h00;
        addr_ok  = 1'b1;
        wd_ok    = 1'b1;
        wb_addr  = {15'($urandom), a};
        wb_we    = w;
        wb_wdata = d;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (wb_stall) stall_n++;
            if (!ram_oe_n) oe_n_cnt++;
            if (!ram_we_n) we_n_cnt++;
            if (ram_doe) doe_n++;
            if (wb_ack) begin
                ack_n++;
                if (ack_k < 0) begin
                    ack_k = k;
                    rd    = wb_rdata;
                end
            end
            if (wb_stall && ram_addr !== a) addr_ok = 1'b0;
            if (!ram_we_n && ram_dout !== d) wd_ok = 1'b0;
            if (k == 0) begin
                wb_stb = 1'b0;
                if (drop) wb_cyc = 1'b0;
            end
        end
        wb_cyc = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++;
        if (wb_stall !== 1'b0 || wb_ack !== 1'b0) begin
            err++;
            $display("FAIL reset_hs: stall=%b ack=%b want 0 0", wb_stall, wb_ack);
        end
        vec++;
        if (ram_oe_n !== 1'b1 || ram_we_n !== 1'b1 || ram_doe !== 1'b0) begin
            err++;
            $display("FAIL reset_ram_ctl: oe_n=%b we_n=%b doe=%b want 1 1 0",
                     ram_oe_n, ram_we_n, ram_doe);
        end
        vec++;
        if (ram_addr !== '0 || ram_dout !== 8'h00 || wb_rdata !== 8'h00) begin
            err++;
            $display("FAIL reset_data: addr=%h dout=%h rdata=%h want 0 0 0",
                     ram_addr, ram_dout, wb_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_read();
        int s, o, w, e, ak, an;
        logic [7:0] rd;
        bit aok, wok;
        xfer(1'b0, 17'h08000, 8'h00, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        vec++;
        if (s != WS + 2) begin
            err++; $display("FAIL read_stall: got %0d want %0d", s, WS + 2);
        end
        vec++;
        if (o != WS + 1 || w != 0 || e != 0) begin
            err++;
            $display("FAIL read_strobes: oe=%0d we=%0d doe=%0d want %0d 0 0",
                     o, w, e, WS + 1);
        end
        vec++;
        if (ak != WS + 1 || an != 1) begin
            err++;
            $display("FAIL read_ack: at=%0d n=%0d want %0d 1", ak, an, WS + 1);
        end
        vec++;
        if (rd !== ref_mem[17'h08000] || !aok) begin
            err++;
            $display("FAIL read_data: got %h want %h addr_ok=%b", rd,
                     ref_mem[17'h08000], aok);
        end
        last_rd = ref_mem[17'h08000];
        vec++;
        if (wb_rdata !== last_rd) begin
            err++;
            $display("FAIL read_hold: got %h want %h", wb_rdata, last_rd);
        end
    endtask

    task automatic test_write();
        int s, o, w, e, ak, an;
        logic [7:0] rd;
        bit aok, wok;
        xfer(1'b1, 17'h00123, 8'h3C, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        ref_mem[17'h00123] = 8'h3C;
        vec++;
        if (w != WS + 1 || o != 0 || e != WS + 2) begin
            err++;
            $display("FAIL write_strobes: we=%0d oe=%0d doe=%0d want %0d 0 %0d",
                     w, o, e, WS + 1, WS + 2);
        end
        vec++;
        if (!wok || !aok || ak != WS + 1 || an != 1) begin
            err++;
            $display("FAIL write_bus: wd_ok=%b addr_ok=%b ack_at=%0d n=%0d want 1 1 %0d 1",
                     wok, aok, ak, an, WS + 1);
        end
        vec++;
        if (sram[17'h00123] !== 8'h3C) begin
            err++;
            $display("FAIL write_mem: got %h want 3c", sram[17'h00123]);
        end
        vec++;
        if (wb_rdata !== last_rd) begin
            err++;
            $display("FAIL write_keeps_rdata: got %h want %h", wb_rdata, last_rd);
        end
    endtask

    task automatic test_random();
        int s, o, w, e, ak, an;
        logic [7:0] rd, d;
        logic [16:0] a;
        logic wr;
        bit aok, wok;
        for (int i = 0; i < 24; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 17'h04000 + 17'($urandom_range(0, 7));
            d  = 8'($urandom);
            xfer(wr, a, d, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
            vec++;
            if (ak != WS + 1 || an != 1 || s != WS + 2 || !aok) begin
                err++;
                $display("FAIL rand_timing[%0d]: ack_at=%0d n=%0d stall=%0d aok=%b want %0d 1 %0d 1",
                         i, ak, an, s, aok, WS + 1, WS + 2);
            end
            if (wr) begin
                ref_mem[a] = d;
                vec++;
                if (!wok || w != WS + 1 || wb_rdata !== last_rd) begin
                    err++;
                    $display("FAIL rand_write[%0d]: wd_ok=%b we=%0d rdata=%h want 1 %0d %h",
                             i, wok, w, wb_rdata, WS + 1, last_rd);
                end
            end else begin
                vec++;
                if (rd !== ref_mem[a] || o != WS + 1) begin
                    err++;
                    $display("FAIL rand_read[%0d]: addr=%h got %h want %h oe=%0d",
                             i, a, rd, ref_mem[a], o);
                end
                last_rd = ref_mem[a];
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks[$];
        logic [7:0] dat[$];
        int accepts;
        bit acc;
        accepts = 0;
        acc     = 1'b0;
        wb_we   = 1'b0;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_addr = {15'd0, 17'h05000};
        for (int c = 0; c < 40; c++) begin
            if (wb_ack) begin
                acks.push_back(c);
                dat.push_back(wb_rdata);
            end
            if (acc) begin
                if (accepts == 4) wb_stb = 1'b0;
                else wb_addr = {15'd0, 17'h05000 + 17'(accepts)};
            end
            acc = wb_stb && !wb_stall;
            if (acc) accepts++;
            @(negedge clk);
        end
        wb_cyc = 1'b0;
        vec++;
        if (acks.size() != 4 || accepts != 4) begin
            err++;
            $display("FAIL b2b_count: acks=%0d accepts=%0d want 4 4",
                     acks.size(), accepts);
        end else begin
            for (int i = 0; i < 4; i++) begin
                vec++;
                if (dat[i] !== ref_mem[17'h05000 + 17'(i)]) begin
                    err++;
                    $display("FAIL b2b_data[%0d]: got %h want %h", i, dat[i],
                             ref_mem[17'h05000 + 17'(i)]);
                end
                if (i > 0) begin
                    vec++;
                    if (acks[i] - acks[i-1] != WS + 3) begin
                        err++;
                        $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i,
                                 acks[i] - acks[i-1], WS + 3);
                    end
                end
            end
            last_rd = ref_mem[17'h05003];
        end
    endtask

    task automatic test_drop_cycle();
        int s, o, w, e, ak, an;
        logic [7:0] rd, d;
        bit aok, wok;
        d = 8'($urandom) | 8'h01;
        d = d ^ ref_mem[17'h06000] ^ ref_mem[17'h06000];
        if (d == ref_mem[17'h06000]) d = ~d;
        xfer(1'b1, 17'h06000, d, 1'b1, s, o, w, e, ak, an, rd, aok, wok);
        ref_mem[17'h06000] = d;
        vec++;
        if (an != 0 || w != WS + 1) begin
            err++;
            $display("FAIL drop_cyc: acks=%0d we=%0d want 0 %0d", an, w, WS + 1);
        end
        vec++;
        if (sram[17'h06000] !== d) begin
            err++;
            $display("FAIL drop_mem: got %h want %h", sram[17'h06000], d);
        end
        xfer(1'b0, 17'h06000, 8'h00, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        vec++;
        if (rd !== ref_mem[17'h06000] || an != 1) begin
            err++;
            $display("FAIL drop_readback: got %h want %h acks=%0d", rd,
                     ref_mem[17'h06000], an);
        end
        last_rd = ref_mem[17'h06000];
    endtask

    task automatic test_reset_mid_write();
        int s, o, w, e, ak, an, seen;
        logic [7:0] rd;
        bit aok, wok;
        seen     = 0;
        wb_addr  = {15'd0, 17'h07000};
        wb_we    = 1'b1;
        wb_wdata = 8'h77;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        @(negedge clk);
        wb_stb = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vec++;
        if (ram_we_n !== 1'b1 || ram_doe !== 1'b0 || wb_stall !== 1'b0) begin
            err++;
            $display("FAIL rst_async: we_n=%b doe=%b stall=%b want 1 0 0",
                     ram_we_n, ram_doe, wb_stall);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_ack) seen++;
        end
        wb_cyc = 1'b0;
        vec++;
        if (seen != 0 || wb_rdata !== 8'h00) begin
            err++;
            $display("FAIL rst_no_ack: acks=%0d rdata=%h want 0 00", seen, wb_rdata);
        end
        xfer(1'b0, 17'h08000, 8'h00, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        vec++;
        if (rd !== ref_mem[17'h08000] || ak != WS + 1 || an != 1) begin
            err++;
            $display("FAIL rst_recover: got %h at %0d n=%0d want %h at %0d 1",
                     rd, ak, an, ref_mem[17'h08000], WS + 1);
        end
    endtask

`ifdef WB_RAM_WRITE_PROTECT_EN
    task automatic test_write_protect();
        int s, o, w, e, ak, an;
        logic [7:0] rd, old;
        bit aok, wok;
        ram_wp = 1'b1;
        old = ref_mem[17'h1C010];
        xfer(1'b1, 17'h1C010, ~old, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        vec++;
        if (ak != WS + 1 || an != 1 || w != 0 || e != 0) begin
            err++;
            $display("FAIL wp_block: ack_at=%0d n=%0d we=%0d doe=%0d want %0d 1 0 0",
                     ak, an, w, e, WS + 1);
        end
        vec++;
        if (sram[17'h1C010] !== old) begin
            err++;
            $display("FAIL wp_mem: got %h want %h", sram[17'h1C010], old);
        end
        xfer(1'b1, 17'h1BFFF, 8'h96, 1'b0, s, o, w, e, ak, an, rd, aok, wok);
        ref_mem[17'h1BFFF] = 8'h96;
        vec++;
        if (sram[17'h1BFFF] !== ref_mem[17'h1BFFF] || w != WS + 1) begin
            err++;
            $display("FAIL wp_below: got %h want %h we=%0d", sram[17'h1BFFF],
                     ref_mem[17'h1BFFF], w);
        end
        ram_wp = 1'b0;
    endtask
`endif

    initial begin
        vec       = 0;
        err       = 0;
        last_rd   = 8'h00;
        sram_init = 1'b0;
        rst       = 1'b1;
        wb_addr   = '0;
        wb_wdata  = '0;
        wb_we     = 1'b0;
        wb_cyc    = 1'b0;
        wb_stb    = 1'b0;
`ifdef WB_RAM_WRITE_PROTECT_EN
        ram_wp    = 1'b0;
`endif
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
        test_reset();
        test_read();
        test_write();
        test_random();
        test_back_to_back();
        test_drop_cycle();
`ifdef WB_RAM_WRITE_PROTECT_EN
        test_write_protect();
`endif
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/wb_ram_responder.md
WB_RAM_RESPONDER -- requirements
Module: wb_ram_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning extra SRAM access cycles per transfer, legal range 0..7.
REQ-002 SHALL have parameter RAM_ADDR_WIDTH, default 17, meaning SRAM address width.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port wb_clock_i, input, 1 bit: bus clock.
REQ-005 SHALL have port reset_i, input, 1 bit: asynchronous reset, active-high.
REQ-006 SHALL have port wb_addr_i, input, WB_ADDR_WIDTH bits: request address.
REQ-007 SHALL have port wb_data_i, input, DATA_WIDTH bits: write data.
REQ-008 SHALL have port wb_data_o, output, DATA_WIDTH bits: read data, valid while wb_ack_o is high.
REQ-009 SHALL have port wb_we_i, input, 1 bit: 0 = read, 1 = write.
REQ-010 SHALL have ports wb_cycle_i and wb_strobe_i, inputs, 1 bit each: Wishbone B4 pipelined cycle and strobe.
REQ-011 SHALL have ports wb_stall_o and wb_ack_o, outputs, 1 bit each.
REQ-012 SHALL have port ram_addr_o, output, RAM_ADDR_WIDTH bits: SRAM address.
REQ-013 SHALL have ports ram_data_i (input) and ram_data_o (output), DATA_WIDTH bits each: SRAM data lines.
REQ-014 SHALL have port ram_data_oe, output, 1 bit: block drives the SRAM data lines.
REQ-015 SHALL have ports ram_oe_n_o and ram_we_n_o, outputs, 1 bit each: active-low SRAM output enable and write enable.

Function
REQ-016 SHALL implement a three-state FSM with states IDLE, ACCESS and ACK.
REQ-017 SHALL drive wb_stall_o combinationally high whenever the state is not IDLE, so at most one transfer is outstanding.
REQ-018 SHALL accept a request on any IDLE edge where wb_cycle_i && wb_strobe_i; on that edge it SHALL register ram_addr_o <= wb_addr_i[RAM_ADDR_WIDTH-1:0], register ram_data_o <= wb_data_i, load the wait counter with WAIT_STATES, and move to ACCESS.
REQ-019 In ACCESS for a read, SHALL hold ram_oe_n_o=0, ram_we_n_o=1 and ram_data_oe=0.
REQ-020 In ACCESS for a write, SHALL hold ram_we_n_o=0, ram_oe_n_o=1 and ram_data_oe=1.
REQ-021 In ACCESS, SHALL decrement the counter on each edge; on the edge where the counter is 0 it SHALL capture ram_data_i into wb_data_o (read only), set ram_oe_n_o=ram_we_n_o=1, and move to ACK.
REQ-022 The ACK state SHALL last exactly one cycle, with wb_ack_o=1 and ram_addr_o held; for writes, ram_data_oe SHALL stay 1 for data hold; the next edge SHALL return to IDLE with ram_data_oe=0 and wb_ack_o=0.
REQ-023 Latency: wb_ack_o SHALL be high in the cycle WAIT_STATES+1 cycles after the accept edge; back-to-back throughput SHALL be one transfer per WAIT_STATES+3 cycles.
REQ-024 With WAIT_STATES=0, ACCESS SHALL last exactly one cycle.
REQ-025 If wb_cycle_i falls mid-transfer, the SRAM access SHALL complete untruncated, and wb_ack_o SHALL be suppressed in ACK if wb_cycle_i is low in that cycle.
REQ-026 wb_data_o SHALL retain its last read value between transfers; writes SHALL NOT modify it.
REQ-027 wb_strobe_i with wb_cycle_i low SHALL be ignored.

Reset
REQ-028 While reset_i is high, the block SHALL asynchronously force state=IDLE, wb_ack_o=0, ram_oe_n_o=1, ram_we_n_o=1, ram_data_oe=0, ram_addr_o=0, ram_data_o=0, wb_data_o=0 and counter=0.
REQ-029 A reset mid-write SHALL release ram_we_n_o immediately, and no ack SHALL follow for that transfer.
REQ-030 The first request SHALL be acceptable on the first edge after reset_i falls.

Configuration
REQ-031 Macro WB_RAM_WRITE_PROTECT_EN SHALL be supported.
REQ-032 When WB_RAM_WRITE_PROTECT_EN is defined, the block SHALL add input port ram_wp_i (1 bit) and parameter WP_BASE.
REQ-033 When WB_RAM_WRITE_PROTECT_EN is defined, a write accepted while ram_wp_i=1 and ram_addr >= WP_BASE SHALL keep ram_we_n_o=1 and ram_data_oe=0 but otherwise follow identical timing and be acked.
REQ-034 When WB_RAM_WRITE_PROTECT_EN is undefined, ram_wp_i and WP_BASE SHALL be absent and all writes SHALL reach the SRAM.

Structure
REQ-035 The FSM state enum typedef, RAM_ADDR_WIDTH and the default wait-state constant SHALL live in common_pkg, which also supplies WB_ADDR_WIDTH and DATA_WIDTH.
REQ-036 The block SHALL be a single module with no sub-module; the counter and FSM are too small to split.

Verification
REQ-037 Read with WAIT_STATES=2: SRAM model returns 8'hA5 at 17'h08000; strobe a read -> stall high for 4 cycles, ram_oe_n_o low for 3 cycles, ack 3 cycles after the accept edge with wb_data_o=8'hA5.
REQ-038 Write 8'h3C to 17'h00123: ram_we_n_o low for 3 cycles with ram_data_o=8'h3C and ram_data_oe high through ACK; the model then holds 8'h3C.
REQ-039 Back-to-back: four strobes with strobe held high -> exactly four acks spaced 5 cycles apart, with no request lost or duplicated.
REQ-040 Drop wb_cycle_i during ACCESS of a write: the SRAM is still written, and no wb_ack_o pulse occurs.
REQ-041 Assert reset_i in the second ACCESS cycle of a write: ram_we_n_o=1 and ram_data_oe=0 asynchronously, no ack, and the next request is served normally.
REQ-042 With WB_RAM_WRITE_PROTECT_EN, WP_BASE=17'h1C000 and ram_wp_i=1: a write to 17'h1C010 is acked, ram_we_n_o stays 1, and the model is unchanged.
